// File: rtl/port_fifo_bridge.sv
// Buffered host I/O port: an inbound (host->CPU) and an outbound
// (CPU->host) first-word-fall-through FIFO with sticky error flags.
module port_fifo_bridge_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    do_pop  = pop && !empty;
    // A pop on the same edge frees the slot a full push needs.
    do_push = push && (!full || do_pop);
    ovf     = push && !do_push;
    unf     = pop && empty;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    if (do_push && !do_pop)
      cnt_d = cnt_q + CW'(1);
    else if (!do_push && do_pop)
      cnt_d = cnt_q - CW'(1);
    valid = !empty;
    rdata = empty ? '0 : mem_q[rptr_q];
    count = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem_q[wptr_q] <= wdata;
  end

endmodule

module port_fifo_bridge #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             port_write,
  input  logic [WIDTH-1:0] port_in,
  output logic             port_full,
  input  logic             port_read,
  output logic [WIDTH-1:0] port_out,
  output logic             port_valid,
  input  logic             cpu_rd,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_rvalid,
  input  logic             cpu_wr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_wfull,
  output logic [CW-1:0]    in_count,
  output logic [CW-1:0]    out_count,
  input  logic             err_clr,
  output logic [3:0]       err_flags
);

  logic       in_ovf, in_unf;
  logic       out_ovf, out_unf;
  logic [3:0] err_q, err_d;

  port_fifo_bridge_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_in (
    .clk   (clk),
    .reset (reset),
    .push  (port_write),
    .pop   (cpu_rd),
    .wdata (port_in),
    .rdata (cpu_rdata),
    .valid (cpu_rvalid),
    .full  (port_full),
    .count (in_count),
    .ovf   (in_ovf),
    .unf   (in_unf)
  );

  port_fifo_bridge_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_out (
    .clk   (clk),
    .reset (reset),
    .push  (cpu_wr),
    .pop   (port_read),
    .wdata (cpu_wdata),
    .rdata (port_out),
    .valid (port_valid),
    .full  (cpu_wfull),
    .count (out_count),
    .ovf   (out_ovf),
    .unf   (out_unf)
  );

  // A new event outranks a clear landing on the same edge.
  always_comb begin
    err_d = err_clr ? 4'b0000 : err_q;
    err_d = err_d | {out_unf, out_ovf, in_unf, in_ovf};
  end

  always_ff @(posedge clk) begin
    if (reset) err_q <= 4'b0000;
    else       err_q <= err_d;
  end

  assign err_flags = err_q;

endmodule

// File: tb/tb_port_fifo_bridge.sv
// Directed bench for port_fifo_bridge (WIDTH=8, DEPTH=4).
// Inputs change #1 after the rising edge; outputs are checked there too.
module tb_port_fifo_bridge;

  logic       clk = 1'b0;
  logic       reset;
  logic       port_write;
  logic [7:0] port_in;
  logic       port_full;
  logic       port_read;
  logic [7:0] port_out;
  logic       port_valid;
  logic       cpu_rd;
  logic [7:0] cpu_rdata;
  logic       cpu_rvalid;
  logic       cpu_wr;
  logic [7:0] cpu_wdata;
  logic       cpu_wfull;
  logic [2:0] in_count;
  logic [2:0] out_count;
  logic       err_clr;
  logic [3:0] err_flags;

  int vectors = 0;
  int miscompares = 0;

  port_fifo_bridge #(.WIDTH(8), .DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .port_write (port_write),
    .port_in    (port_in),
    .port_full  (port_full),
    .port_read  (port_read),
    .port_out   (port_out),
    .port_valid (port_valid),
    .cpu_rd     (cpu_rd),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_wr     (cpu_wr),
    .cpu_wdata  (cpu_wdata),
    .cpu_wfull  (cpu_wfull),
    .in_count   (in_count),
    .out_count  (out_count),
    .err_clr    (err_clr),
    .err_flags  (err_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " port_valid"}, 32'(port_valid), 32'd0);
    chk({tag, " cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
    chk({tag, " port_full"},  32'(port_full),  32'd0);
    chk({tag, " cpu_wfull"},  32'(cpu_wfull),  32'd0);
    chk({tag, " port_out"},   32'(port_out),   32'd0);
    chk({tag, " cpu_rdata"},  32'(cpu_rdata),  32'd0);
    chk({tag, " in_count"},   32'(in_count),   32'd0);
    chk({tag, " out_count"},  32'(out_count),  32'd0);
  endtask

  initial begin
    reset = 1'b1;
    port_write = 1'b0; port_in = 8'h00; port_read = 1'b0;
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00; err_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_idle("reset");
    chk("reset err", 32'(err_flags), 32'h0);
    repeat (5) tick();
    chk_idle("idle");
    chk("idle err", 32'(err_flags), 32'h0);

    // Host -> CPU ordering and occupancy.
    port_write = 1'b1;
    for (int i = 0; i < 3; i++) begin
      port_in = 8'h11 * 8'(i + 1);
      tick();
      chk("in push count", 32'(in_count), 32'(i + 1));
      chk("in push head", 32'(cpu_rdata), 32'h11);
    end
    port_write = 1'b0;
    chk("in rvalid", 32'(cpu_rvalid), 32'd1);
    cpu_rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("in pop data", 32'(cpu_rdata), 32'h11 * 32'(i + 1));
      tick();
      chk("in pop count", 32'(in_count), 32'(2 - i));
    end
    cpu_rd = 1'b0;
    chk("in drained rvalid", 32'(cpu_rvalid), 32'd0);
    chk("in drained rdata", 32'(cpu_rdata), 32'd0);

    // Outbound overflow: fifth write is dropped.
    cpu_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cpu_wdata = 8'hA0 + 8'(i);
      tick();
      chk("out fill count", 32'(out_count), (i < 3) ? 32'(i + 1) : 32'd4);
      chk("out fill full", 32'(cpu_wfull), (i < 3) ? 32'd0 : 32'd1);
      chk("out fill err", 32'(err_flags), (i < 4) ? 32'h0 : 32'h4);
    end
    cpu_wr = 1'b0;
    port_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("out pop data", 32'(port_out), 32'hA0 + 32'(i));
      tick();
    end
    port_read = 1'b0;
    chk("out drained valid", 32'(port_valid), 32'd0);
    chk("out drained count", 32'(out_count), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr err", 32'(err_flags), 32'h0);

    // Push and pop together on a full outbound FIFO.
    cpu_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_wdata = 8'hC0 + 8'(i);
      tick();
    end
    cpu_wdata = 8'hB5;
    port_read = 1'b1;
    chk("full rw head", 32'(port_out), 32'hC0);
    tick();
    cpu_wr = 1'b0;
    chk("full rw count", 32'(out_count), 32'd4);
    chk("full rw err", 32'(err_flags), 32'h0);
    chk("full rw head2", 32'(port_out), 32'hC1);
    for (int i = 0; i < 4; i++) begin
      chk("full rw pop", 32'(port_out), (i < 3) ? 32'hC1 + 32'(i) : 32'hB5);
      tick();
    end
    port_read = 1'b0;
    chk("full rw empty", 32'(port_valid), 32'd0);

    // Underflow with a simultaneous push.
    cpu_rd = 1'b1;
    port_write = 1'b1;
    port_in = 8'h5A;
    tick();
    cpu_rd = 1'b0;
    port_write = 1'b0;
    chk("unf err", 32'(err_flags), 32'h2);
    chk("unf count", 32'(in_count), 32'd1);
    chk("unf data", 32'(cpu_rdata), 32'h5A);
    err_clr = 1'b1;
    tick();
    chk("unf clr", 32'(err_flags), 32'h0);
    port_read = 1'b1;
    tick();
    port_read = 1'b0;
    chk("clr vs event", 32'(err_flags), 32'h8);
    tick();
    err_clr = 1'b0;
    chk("clr again", 32'(err_flags), 32'h0);

    // Reset with data queued and a push in flight.
    port_write = 1'b1;
    port_in = 8'h61;
    tick();
    port_in = 8'h62;
    tick();
    chk("pre-reset count", 32'(in_count), 32'd3);
    port_in = 8'h77;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    port_write = 1'b0;
    chk_idle("mid reset");

    // Streaming through pointer wrap-around.
    port_write = 1'b1;
    port_in = 8'h80;
    tick();
    cpu_rd = 1'b1;
    for (int i = 1; i < 10; i++) begin
      port_in = 8'h80 + 8'(i);
      chk("wrap head", 32'(cpu_rdata), 32'h80 + 32'(i - 1));
      tick();
      chk("wrap count", 32'(in_count), 32'd1);
    end
    port_write = 1'b0;
    chk("wrap last", 32'(cpu_rdata), 32'h89);
    tick();
    cpu_rd = 1'b0;
    chk("wrap empty", 32'(in_count), 32'd0);
    chk("wrap err", 32'(err_flags), 32'h0);

    // Inbound overflow.
    port_write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      port_in = 8'hD0 + 8'(i);
      tick();
    end
    port_write = 1'b0;
    chk("in ovf full", 32'(port_full), 32'd1);
    chk("in ovf count", 32'(in_count), 32'd4);
    chk("in ovf err", 32'(err_flags), 32'h1);
    chk("in ovf head", 32'(cpu_rdata), 32'hD0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
